// File: rtl/fnd_scan_ctrl_if.sv
// Load handshake bundle between a value producer (master) and fnd_scan_ctrl (slave).
interface fnd_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_data;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    ready;

    modport master (output load, load_data, dp_in, input ready);
    modport slave  (input load, load_data, dp_in, output ready);
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with frame-aligned commit.
// Optional digit blinking is enabled by defining FND_BLINK_EN.
module fnd_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500
`ifdef FND_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fnd_scan_ctrl_if.slave        bus,
    input  logic                  lz_en,
`ifdef FND_BLINK_EN
    input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
    output logic [3:0]            digit_num,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  dp_n,
    output logic                  frame_tick
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DW    = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;
    // With no blanking interval every slot starts (and stays) in SHOW.
    localparam state_t ST_SLOT0 = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;

    logic [CNT_W-1:0]      slot_cnt_r;
    logic [IDX_W-1:0]      digit_idx_r;
    state_t                state_r, state_nxt_s;
    logic                  slot_wrap_s, frame_wrap_s;
    logic [DW-1:0]         display_r, shadow_r;
    logic [NUM_DIGITS-1:0] dp_r, shadow_dp_r;
    logic                  pending_r;
    logic [NUM_DIGITS-1:0] supp_s, blink_supp_s;
    logic [NUM_DIGITS-1:0] sel_nxt_s;
    logic [3:0]            num_nxt_s;
    logic                  dp_n_nxt_s;
    logic [NUM_DIGITS-1:0] digit_sel_r;
    logic [3:0]            digit_num_r;
    logic                  dp_n_r, frame_tick_r;

    // Digit k>0 is a leading zero when it and every more significant nibble are zero.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DW-1:0] v, input logic en);
        logic [NUM_DIGITS-1:0] mask;
        logic                  zero_above;
        mask       = {NUM_DIGITS{1'b0}};
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_above = zero_above && (v[4*k +: 4] == 4'h0);
            mask[k]    = en && zero_above;
        end
        return mask;
    endfunction

    assign slot_wrap_s  = (slot_cnt_r == SLOT_LAST);
    assign frame_wrap_s = slot_wrap_s && (digit_idx_r == IDX_LAST);
    assign bus.ready    = ~pending_r;

    // Slot cycle counter and current digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_r  <= {CNT_W{1'b0}};
            digit_idx_r <= {IDX_W{1'b0}};
        end else if (slot_wrap_s) begin
            slot_cnt_r  <= {CNT_W{1'b0}};
            digit_idx_r <= frame_wrap_s ? {IDX_W{1'b0}} : digit_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            slot_cnt_r  <= slot_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Slot phase state register; tracks slot_cnt >= BLANK_CYC in lockstep with the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_SLOT0;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Slot phase next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BLANK: begin
                if (slot_cnt_r == BLANK_LAST) state_nxt_s = ST_SHOW;
                else                          state_nxt_s = ST_BLANK;
            end
            ST_SHOW: begin
                if (slot_wrap_s) state_nxt_s = ST_SLOT0;
                else             state_nxt_s = ST_SHOW;
            end
            default: state_nxt_s = ST_SLOT0;
        endcase
    end

`ifdef FND_BLINK_EN
    localparam int BF_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);
    logic [BF_W-1:0] frame_cnt_r;
    logic            blink_phase_r;

    // Blink phase flips after every BLINK_FRAMES frame wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r   <= {BF_W{1'b0}};
            blink_phase_r <= 1'b0;
        end else if (frame_wrap_s) begin
            if (frame_cnt_r == BF_LAST) begin
                frame_cnt_r   <= {BF_W{1'b0}};
                blink_phase_r <= ~blink_phase_r;
            end else begin
                frame_cnt_r   <= frame_cnt_r + {{(BF_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign blink_supp_s = blink_phase_r ? blink_mask : {NUM_DIGITS{1'b0}};
`else
    assign blink_supp_s = {NUM_DIGITS{1'b0}};
`endif

    assign supp_s = lz_mask(display_r, lz_en) | blink_supp_s;

    // Output decode: a suppressed digit keeps its whole slot dark, dp included.
    always_comb begin
        num_nxt_s = display_r[{digit_idx_r, 2'b00} +: 4];
        if ((state_r == ST_SHOW) && !supp_s[digit_idx_r]) begin
            sel_nxt_s  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx_r);
            dp_n_nxt_s = ~dp_r[digit_idx_r];
        end else begin
            sel_nxt_s  = {NUM_DIGITS{1'b1}};
            dp_n_nxt_s = 1'b1;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_sel_r  <= {NUM_DIGITS{1'b1}};
            digit_num_r  <= 4'h0;
            dp_n_r       <= 1'b1;
            frame_tick_r <= 1'b0;
        end else begin
            digit_sel_r  <= sel_nxt_s;
            digit_num_r  <= num_nxt_s;
            dp_n_r       <= dp_n_nxt_s;
            frame_tick_r <= frame_wrap_s;
        end
    end

    // Shadow capture on accepted load; commit to the display only at a frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_r   <= {DW{1'b0}};
            dp_r        <= {NUM_DIGITS{1'b0}};
            shadow_r    <= {DW{1'b0}};
            shadow_dp_r <= {NUM_DIGITS{1'b0}};
            pending_r   <= 1'b0;
        end else if (frame_wrap_s && pending_r) begin
            display_r   <= shadow_r;
            dp_r        <= shadow_dp_r;
            pending_r   <= 1'b0;
        end else if (bus.load && !pending_r) begin
            shadow_r    <= bus.load_data;
            shadow_dp_r <= bus.dp_in;
            pending_r   <= 1'b1;
        end
    end

    assign digit_sel  = digit_sel_r;
    assign digit_num  = digit_num_r;
    assign dp_n       = dp_n_r;
    assign frame_tick = frame_tick_r;
endmodule
